lsrc_seq: RTL and testbench

- Serial stimulus sequencer that sits directly upstream of ldut and drives its 1-bit input a.
- Accepts a parallel word plus a repeat count over a valid/ready handshake.
- Replays the word LSB-first, one bit per clock, (count+1) times back-to-back, then returns the line to a programmable idle level.
- Gives the ldut -> psys inverter chain real sequential, toggle-rich stimulus for coverage diagnostics.

---
 rtl/lsrc_pkg.sv | 15 +
 rtl/lsrc_cnt.sv | 33 +++
 rtl/lsrc_seq.sv | 123 ++++++++++++
 tb/tb_lsrc_seq.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsrc_pkg.sv
// Shared types and helpers for the lsrc serial stimulus sequencer.
package lsrc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Width of a counter that indexes `width` bit positions.
   function automatic int cnt_w(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/lsrc_cnt.sv
// Modulo-MOD counter (up or down) with load and a zero-state flag,
// used both as the bit-position counter and as the pass counter.
module lsrc_cnt #(
   parameter int W    = 3,
   parameter int MOD  = 8,
   parameter bit DOWN = 1'b0
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         zero
);

   localparam logic [W-1:0] LAST = W'(MOD - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en) begin
         if (DOWN) cnt <= (cnt == '0) ? LAST : cnt - 1'b1;
         else      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/lsrc_seq.sv
// Serial stimulus sequencer: replays a captured word LSB-first (count+1) times,
// then returns a_out to the programmable idle level.
module lsrc_seq
   import lsrc_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int REP_W = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   input  logic [REP_W-1:0] load_count,
   input  logic             idle_val,
   input  logic             abort,
   output logic             a_out,
   output logic             a_valid,
   output logic             busy,
   output logic             done,
   output logic             aborted
);

   localparam int CW = cnt_w(WIDTH);

   state_t           state, state_n;
   logic [WIDTH-1:0] word, word_n;
   logic             a_out_n, a_valid_n, busy_n, done_n, aborted_n;
   logic             bit_load, bit_en, bit_zero;
   logic             pass_load, pass_en, pass_zero;

   // The word is kept rotated so the next bit to send is always word[0];
   // bit_cnt == 0 in SHIFT therefore marks the end of a pass.
   lsrc_cnt #(.W(CW), .MOD(WIDTH), .DOWN(1'b0)) u_bit_cnt (
      .clock    (clock),
      .reset_n  (reset_n),
      .load     (bit_load),
      .load_val (CW'(1)),
      .en       (bit_en),
      .zero     (bit_zero)
   );

   lsrc_cnt #(.W(REP_W), .MOD(2**REP_W), .DOWN(1'b1)) u_pass_cnt (
      .clock    (clock),
      .reset_n  (reset_n),
      .load     (pass_load),
      .load_val (load_count),
      .en       (pass_en),
      .zero     (pass_zero)
   );

   assign load_ready = (state == IDLE);

   // NOTE: every always_comb output gets a default first so no path leaves a latch.
   always_comb begin
      state_n   = state;
      word_n    = word;
      a_out_n   = idle_val;
      a_valid_n = 1'b0;
      busy_n    = 1'b0;
      done_n    = 1'b0;
      aborted_n = 1'b0;
      bit_load  = 1'b0;
      bit_en    = 1'b0;
      pass_load = 1'b0;
      pass_en   = 1'b0;
      case (state)
         IDLE: begin
            if (load_valid) begin
               state_n   = SHIFT;
               word_n    = {load_data[0], load_data[WIDTH-1:1]};
               a_out_n   = load_data[0];
               a_valid_n = 1'b1;
               busy_n    = 1'b1;
               bit_load  = 1'b1;
               pass_load = 1'b1;
            end
         end
         SHIFT: begin
            if (abort) begin
               state_n   = DONE;
               done_n    = 1'b1;
               aborted_n = 1'b1;
            end else if (bit_zero && pass_zero) begin
               state_n = DONE;
               done_n  = 1'b1;
            end else begin
               word_n    = {word[0], word[WIDTH-1:1]};
               a_out_n   = word[0];
               a_valid_n = 1'b1;
               busy_n    = 1'b1;
               bit_en    = 1'b1;
               pass_en   = bit_zero;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // NOTE: state is non-blocking so every register sees pre-edge values; the
   // pattern word is reset too, so no stale data survives a mid-stream reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         word    <= '0;
         a_out   <= 1'b0;
         a_valid <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         aborted <= 1'b0;
      end else begin
         state   <= state_n;
         word    <= word_n;
         a_out   <= a_out_n;
         a_valid <= a_valid_n;
         busy    <= busy_n;
         done    <= done_n;
         aborted <= aborted_n;
      end
   end

endmodule

// File: tb/tb_lsrc_seq.sv
// Scoreboard bench for lsrc_seq: stimulus pushes expected bits and end events,
// a negedge monitor pops and compares whatever the sequencer presents.
module tb_lsrc_seq;

   localparam int WIDTH = 8;
   localparam int REP_W = 4;

   logic             clock = 1'b0;
   logic             reset_n;
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_data;
   logic [REP_W-1:0] load_count;
   logic             idle_val;
   logic             abort;
   logic             a_out, a_valid, busy, done, aborted;

   // Downstream inverter chain: ldut b = ~a, psys c = ~b.
   logic b, c;
   assign b = ~a_out;
   assign c = ~b;

   typedef struct packed {
      logic ab;
      logic lvl;
   } end_t;

   logic exp_bits[$];
   end_t exp_ends[$];
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;

   lsrc_seq #(.WIDTH(WIDTH), .REP_W(REP_W)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .load_count (load_count),
      .idle_val   (idle_val),
      .abort      (abort),
      .a_out      (a_out),
      .a_valid    (a_valid),
      .busy       (busy),
      .done       (done),
      .aborted    (aborted)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares each presented bit and end-of-stream event to the queues.
   logic exp_bit;
   end_t exp_end;
   always @(negedge clock) begin
      if (reset_n && mon_en) begin
         if (a_valid) begin
            if (exp_bits.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_bit a_out=%0d at %0t", a_out, $time);
            end else begin
               exp_bit = exp_bits.pop_front();
               check("stream_bit", a_out, exp_bit);
               check("busy_in_shift", busy, 1);
            end
         end
         if (done) begin
            if (exp_ends.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done at %0t", $time);
            end else begin
               exp_end = exp_ends.pop_front();
               check("done_aborted", aborted, exp_end.ab);
               check("done_level", a_out, exp_end.lvl);
               check("done_ready_low", load_ready, 0);
               check("done_valid_low", a_valid, 0);
               check("done_busy_low", busy, 0);
            end
         end else if (aborted) begin
            checks++;
            errors++;
            $display("FAIL aborted_without_done at %0t", $time);
         end
      end
   end

   task automatic push_stream(input logic [WIDTH-1:0] data, input int count, input int abort_after);
      if (abort_after > 0) begin
         for (int i = 0; i < abort_after; i++) exp_bits.push_back(data[i % WIDTH]);
      end else begin
         for (int p = 0; p <= count; p++)
            for (int i = 0; i < WIDTH; i++) exp_bits.push_back(data[i]);
      end
      exp_ends.push_back('{ab: (abort_after > 0), lvl: idle_val});
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!load_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      check("ready_wait", load_ready, 1);
   endtask

   task automatic wait_done();
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!done && n < 300);
      check("done_seen", done, 1);
      @(negedge clock);
      check("ready_after_done", load_ready, 1);
      check("idle_valid_low", a_valid, 0);
   endtask

   task automatic send(input logic [WIDTH-1:0] data, input int count, input int abort_after);
      wait_ready();
      push_stream(data, count, abort_after);
      load_data  = data;
      load_count = REP_W'(count);
      load_valid = 1'b1;
      @(posedge clock);
      #1 load_valid = 1'b0;
      if (abort_after > 0) begin
         repeat (abort_after - 1) @(posedge clock);
         #1 abort = 1'b1;
         @(posedge clock);
         #1 abort = 1'b0;
      end
      wait_done();
   endtask

   initial begin
      reset_n    = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      load_count = '0;
      idle_val   = 1'b1;
      abort      = 1'b0;

      #12;
      check("rst_a_out", a_out, 0);
      check("rst_a_valid", a_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_load_ready", load_ready, 1);
      @(negedge clock);
      reset_n = 1'b1;
      mon_en  = 1'b1;
      @(negedge clock);
      check("idle_level_hi", a_out, 1);

      // Basic stream, multi-pass stream, abort on the 3rd shift cycle.
      send(8'hA5, 0, 0);
      send(8'h01, 2, 0);
      send(8'hC6, 3, 3);

      // abort outside SHIFT is ignored.
      abort = 1'b1;
      repeat (3) begin
         @(negedge clock);
         check("idle_abort_ready", load_ready, 1);
         check("idle_abort_done", done, 0);
      end
      abort = 1'b0;

      // load_valid held high, alternating patterns, garbage data while shifting.
      load_count = '0;
      load_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         int n;
         load_data = k[0] ? 8'h00 : 8'hFF;
         push_stream(load_data, 0, 0);
         n = 0;
         while (!load_ready && n < 50) begin
            @(negedge clock);
            n++;
         end
         check("b2b_ready", load_ready, 1);
         @(posedge clock);
         #1 load_data = 8'h3C;
         n = 0;
         do begin
            @(negedge clock);
            n++;
         end while (!done && n < 50);
         check("b2b_done", done, 1);
         if (k == 3) load_valid = 1'b0;
         @(negedge clock);
         check("b2b_gap_ready", load_ready, 1);
         check("b2b_gap_valid", a_valid, 0);
      end
      load_valid = 1'b0;

      // Maximum repeat count: 16 passes.
      send(8'h96, 15, 0);

      // idle_val change shows on a_out one cycle later; downstream levels.
      #1 idle_val = 1'b0;
      @(posedge clock);
      @(negedge clock);
      check("idle_level_lo", a_out, 0);
      check("ldut_b_idle", b, 1);
      check("psys_c_idle", c, 0);

      // Toggling pattern through the inverter chain.
      wait_ready();
      push_stream(8'h55, 0, 0);
      load_data  = 8'h55;
      load_count = '0;
      load_valid = 1'b1;
      @(posedge clock);
      #1 load_valid = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         @(negedge clock);
         check("ldut_b_toggle", b, (i % 2 == 0) ? 0 : 1);
         check("psys_c_toggle", c, (i % 2 == 0) ? 1 : 0);
      end
      wait_done();

      // Reset mid-stream: immediate idle outputs, no done pulse afterwards.
      mon_en     = 1'b0;
      idle_val   = 1'b1;
      load_data  = 8'hFF;
      load_count = 4'd3;
      load_valid = 1'b1;
      @(posedge clock);
      #1 load_valid = 1'b0;
      repeat (5) @(posedge clock);
      #3 reset_n = 1'b0;
      #1;
      check("mid_rst_a_out", a_out, 0);
      check("mid_rst_a_valid", a_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ready", load_ready, 1);
      check("mid_rst_done", done, 0);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (3) begin
         @(negedge clock);
         check("post_rst_done", done, 0);
         check("post_rst_valid", a_valid, 0);
      end

      check("bits_left", exp_bits.size(), 0);
      check("ends_left", exp_ends.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
